// File: rtl/mc_ctrl_if.sv
//==============================================================================
// Module   : mc_ctrl_if
// Purpose  : Bundle of datapath-facing signals for the multicycle MIPS
//            sequencer: IR fields and flags in, strobes/selects/status out.
// Modports : master - the sequencer (consumes op/funct/zero/dm_rdy)
//            slave  - the datapath / memory side (drives op/funct/zero/dm_rdy)
// Signals  : op, funct, zero, dm_rdy, PCWr, IRWr, RFWr, DMWr, dm_req, NPCOp,
//            EXTOp, ALUOp, BSel, WDSel, GPRSel, state, err,
//            retire_cnt (only with MC_RETIRE_CNT_EN)
// Config   : MC_RETIRE_CNT_EN adds parameter CNT_W and retire_cnt
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mc_ctrl_if
`ifdef MC_RETIRE_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       dm_rdy;
  logic       PCWr;
  logic       IRWr;
  logic       RFWr;
  logic       DMWr;
  logic       dm_req;
  logic [1:0] NPCOp;
  logic [1:0] EXTOp;
  logic [1:0] ALUOp;
  logic       BSel;
  logic [1:0] WDSel;
  logic [1:0] GPRSel;
  logic [3:0] state;
  logic       err;
`ifdef MC_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt;
`endif

  modport master (
    input  op, funct, zero, dm_rdy,
    output PCWr, IRWr, RFWr, DMWr, dm_req, NPCOp, EXTOp, ALUOp, BSel,
    output WDSel, GPRSel,
`ifdef MC_RETIRE_CNT_EN
    output retire_cnt,
`endif
    output state, err
  );

  modport slave (
    output op, funct, zero, dm_rdy,
    input  PCWr, IRWr, RFWr, DMWr, dm_req, NPCOp, EXTOp, ALUOp, BSel,
    input  WDSel, GPRSel,
`ifdef MC_RETIRE_CNT_EN
    input  retire_cnt,
`endif
    input  state, err
  );
endinterface

`default_nettype wire

// File: rtl/mc_ctrl.sv
//==============================================================================
// Module   : mc_ctrl
// Purpose  : Multicycle sequencer for a single-issue MIPS datapath. Steps each
//            instruction through FETCH/DCD/EXE/MA/MR/MW/WB/BR/JMP, emits
//            one-cycle write strobes and mux selects, and handshakes with a
//            variable-latency data memory. Illegal instructions and memory
//            timeouts park the core in HALT with a sticky err flag.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous reset, active low
//            bus  - mc_ctrl_if.master (IR fields/flags in, controls out)
// Params   : MEM_TIMEOUT - MR/MW cycles without dm_rdy before HALT (<=15)
//            CNT_W       - retire counter width (MC_RETIRE_CNT_EN only)
// Config   : `define MC_RETIRE_CNT_EN to build the retired-instruction counter
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mc_ctrl #(
  parameter int MEM_TIMEOUT = 15
`ifdef MC_RETIRE_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mc_ctrl_if.master  bus
);

  localparam logic [3:0] c_FETCH = 4'd0;
  localparam logic [3:0] c_DCD   = 4'd1;
  localparam logic [3:0] c_EXE   = 4'd2;
  localparam logic [3:0] c_MA    = 4'd3;
  localparam logic [3:0] c_MR    = 4'd4;
  localparam logic [3:0] c_MW    = 4'd5;
  localparam logic [3:0] c_WB    = 4'd6;
  localparam logic [3:0] c_BR    = 4'd7;
  localparam logic [3:0] c_JMP   = 4'd8;
  localparam logic [3:0] c_HALT  = 4'd15;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_FN_ADDU  = 6'b100001;
  localparam logic [5:0] c_FN_SUBU  = 6'b100011;

  // The wait counter holds the number of stalled cycles already spent, so the
  // cycle that sees MEM_TIMEOUT-1 without dm_rdy is the last one allowed.
  localparam logic [3:0] c_WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  logic [3:0] r_state;
  logic [3:0] w_nextState;
  logic [3:0] r_waitCnt;
  logic       r_err;

  logic w_isAddu, w_isSubu, w_isR, w_isOri, w_isLui, w_isLw, w_isSw;
  logic w_isBeq, w_isJ, w_isJal, w_inMem, w_memTimeout;

  assign w_isAddu = (bus.op == c_OP_RTYPE) && (bus.funct == c_FN_ADDU);
  assign w_isSubu = (bus.op == c_OP_RTYPE) && (bus.funct == c_FN_SUBU);
  assign w_isR    = w_isAddu || w_isSubu;
  assign w_isOri  = (bus.op == c_OP_ORI);
  assign w_isLui  = (bus.op == c_OP_LUI);
  assign w_isLw   = (bus.op == c_OP_LW);
  assign w_isSw   = (bus.op == c_OP_SW);
  assign w_isBeq  = (bus.op == c_OP_BEQ);
  assign w_isJ    = (bus.op == c_OP_J);
  assign w_isJal  = (bus.op == c_OP_JAL);

  assign w_inMem      = (r_state == c_MR) || (r_state == c_MW);
  // dm_rdy in the final allowed cycle still completes the access.
  assign w_memTimeout = (r_waitCnt == c_WAIT_LAST) && !bus.dm_rdy;

  // State register plus wait counter and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_FETCH;
      r_waitCnt <= 4'd0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == c_MA) begin
        r_waitCnt <= 4'd0;
      end else if (w_inMem && !bus.dm_rdy) begin
        r_waitCnt <= r_waitCnt + 4'd1;
      end
      if (w_nextState == c_HALT) begin
        r_err <= 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = c_HALT;
    case (r_state)
      c_FETCH: w_nextState = c_DCD;
      c_DCD: begin
        if (w_isR || w_isOri || w_isLui) w_nextState = c_EXE;
        else if (w_isLw || w_isSw)       w_nextState = c_MA;
        else if (w_isBeq)                w_nextState = c_BR;
        else if (w_isJ || w_isJal)       w_nextState = c_JMP;
        else                             w_nextState = c_HALT;
      end
      c_EXE:   w_nextState = c_WB;
      c_WB:    w_nextState = c_FETCH;
      c_MA:    w_nextState = w_isLw ? c_MR : c_MW;
      c_MR:    w_nextState = bus.dm_rdy ? c_WB :
                             (w_memTimeout ? c_HALT : c_MR);
      c_MW:    w_nextState = bus.dm_rdy ? c_FETCH :
                             (w_memTimeout ? c_HALT : c_MW);
      c_BR:    w_nextState = c_FETCH;
      c_JMP:   w_nextState = c_FETCH;
      default: w_nextState = c_HALT;
    endcase
  end

  // Output logic. Everything is forced idle while reset is asserted so that
  // the FETCH strobes do not fire during reset.
  always_comb begin
    bus.PCWr   = 1'b0;
    bus.IRWr   = 1'b0;
    bus.RFWr   = 1'b0;
    bus.DMWr   = 1'b0;
    bus.dm_req = 1'b0;
    bus.NPCOp  = 2'b00;
    bus.EXTOp  = 2'b00;
    bus.ALUOp  = 2'b00;
    bus.BSel   = 1'b0;
    bus.WDSel  = 2'b00;
    bus.GPRSel = 2'b00;
    if (rst) begin
      case (r_state)
        c_FETCH: begin
          bus.IRWr = 1'b1;
          bus.PCWr = 1'b1;
        end
        c_EXE: begin
          if (w_isSubu) begin
            bus.ALUOp = 2'b01;
          end else if (w_isOri || w_isLui) begin
            bus.ALUOp = 2'b10;
            bus.BSel  = 1'b1;
            bus.EXTOp = w_isLui ? 2'b10 : 2'b00;
          end
        end
        c_WB: begin
          bus.RFWr   = 1'b1;
          bus.GPRSel = w_isR ? 2'b00 : 2'b01;
          bus.WDSel  = w_isLw ? 2'b01 : 2'b00;
        end
        // Address computation stays driven through the whole memory wait.
        c_MA, c_MR, c_MW: begin
          bus.BSel   = 1'b1;
          bus.EXTOp  = 2'b01;
          bus.dm_req = (r_state != c_MA);
          bus.DMWr   = (r_state == c_MW);
        end
        c_BR: begin
          bus.ALUOp = 2'b01;
          bus.EXTOp = 2'b01;
          bus.NPCOp = 2'b01;
          bus.PCWr  = bus.zero;
        end
        c_JMP: begin
          bus.PCWr  = 1'b1;
          bus.NPCOp = 2'b10;
          if (w_isJal) begin
            bus.RFWr   = 1'b1;
            bus.GPRSel = 2'b10;
            bus.WDSel  = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.state = r_state;
  assign bus.err   = r_err;

`ifdef MC_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retireCnt;
  logic             w_retire;

  // HALT is never a retirement; only completed instructions returning to FETCH.
  assign w_retire = (w_nextState == c_FETCH) &&
                    ((r_state == c_WB) || (r_state == c_MW) ||
                     (r_state == c_BR) || (r_state == c_JMP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retireCnt <= '0;
    end else if (w_retire) begin
      r_retireCnt <= r_retireCnt + CNT_W'(1);
    end
  end

  assign bus.retire_cnt = r_retireCnt;
`endif

endmodule

`default_nettype wire
